// File: rtl/uart_rx_pkg.sv
// ============================================================================
//  Module   : uart_rx_pkg
//  Purpose  : Shared constants for the UART receive deserializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter.sv
// ============================================================================
//  Module   : uart_rx_edge_bit_counter
//  Purpose  : Oversampling edge counter, bit counter and sample-point strobes.
//             Macro UART_RX_MAJORITY_VOTE_EN adds the two early vote strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_active,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_bit_end,
    output logic                  o_sample_dec
`ifdef UART_RX_MAJORITY_VOTE_EN
    ,
    output logic                  o_sample_early,
    output logic                  o_sample_mid
`endif
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0] w_half;

    assign w_half = i_prescale >> 1;

    // The start-detect cycle is edge 0, so the first counted cycle is edge 1.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (i_start) begin
            edge_cnt_d = PRESCALE_W'(1);
            bit_cnt_d  = '0;
        end else if (!i_active) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (o_bit_end) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_bit_cnt    = bit_cnt_q;
    assign o_bit_end    = i_active && (edge_cnt_q == i_prescale - PRESCALE_W'(1));
    assign o_sample_dec = i_active && (edge_cnt_q == w_half + PRESCALE_W'(1));
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign o_sample_early = i_active && (edge_cnt_q == w_half - PRESCALE_W'(1));
    assign o_sample_mid   = i_active && (edge_cnt_q == w_half);
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ============================================================================
//  Module   : uart_rx_deserializer
//  Purpose  : UART receiver: start detect, mid-bit sampling, parity/stop check.
//             Macro UART_RX_MAJORITY_VOTE_EN enables 3-sample majority voting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  armed_q, armed_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_err_rec_q, par_err_rec_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  w_start;
    logic                  w_active;
    logic [PRESCALE_W-1:0] w_prescale_sel;
    logic [BIT_CNT_W-1:0]  w_bit_cnt;
    logic                  w_bit_end;
    logic                  w_sample_dec;
    logic                  w_bit;
    logic                  w_par_exp;

    assign w_start  = (state_q == ST_IDLE) && armed_q && !RX_IN;
    assign w_active = (state_q != ST_IDLE);

    // Illegal ratios fall back to 8 so a misprogrammed link still frames.
    assign w_prescale_sel = ((Prescale == PRESCALE_W'(PRESCALE_16)) ||
                             (Prescale == PRESCALE_W'(PRESCALE_32)))
                            ? Prescale : PRESCALE_W'(PRESCALE_8);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic w_sample_early, w_sample_mid;
    logic vote_a_q, vote_a_d, vote_b_q, vote_b_d;

    always_comb begin
        vote_a_d = vote_a_q;
        vote_b_d = vote_b_q;
        if (w_sample_early) vote_a_d = RX_IN;
        if (w_sample_mid)   vote_b_d = RX_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vote_a_q <= 1'b0;
            vote_b_q <= 1'b0;
        end else begin
            vote_a_q <= vote_a_d;
            vote_b_q <= vote_b_d;
        end
    end

    assign w_bit = (vote_a_q & vote_b_q) | (vote_a_q & RX_IN) | (vote_b_q & RX_IN);
`else
    assign w_bit = RX_IN;
`endif

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .clk            (CLK),
        .rst            (RST),
        .i_start        (w_start),
        .i_active       (w_active),
        .i_prescale     (prescale_q),
        .o_bit_cnt      (w_bit_cnt),
        .o_bit_end      (w_bit_end),
        .o_sample_dec   (w_sample_dec)
`ifdef UART_RX_MAJORITY_VOTE_EN
        ,
        .o_sample_early (w_sample_early),
        .o_sample_mid   (w_sample_mid)
`endif
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_start) state_d = ST_START;
            ST_START: begin
                if (w_sample_dec && w_bit) state_d = ST_IDLE;
                else if (w_bit_end)        state_d = ST_DATA;
            end
            ST_DATA:   if (w_bit_end && (w_bit_cnt == LAST_DATA_BIT))
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_end) state_d = ST_STOP;
            ST_STOP:   if (w_sample_dec) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign w_par_exp = (par_typ_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        armed_d       = armed_q;
        prescale_d    = prescale_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        shift_d       = shift_q;
        par_err_rec_d = par_err_rec_q;
        p_data_d      = p_data_q;
        data_valid_d  = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        // A low stop bit disarms start detection until the line returns high.
        if ((state_q == ST_IDLE) && !armed_q && RX_IN) armed_d = 1'b1;
        if (w_start) begin
            prescale_d    = w_prescale_sel;
            par_en_d      = PAR_EN;
            par_typ_d     = PAR_TYP;
            shift_d       = '0;
            par_err_rec_d = 1'b0;
        end
        case (state_q)
            ST_DATA:   if (w_sample_dec) shift_d = {w_bit, shift_q[DATA_WIDTH-1:1]};
            ST_PARITY: if (w_sample_dec) par_err_rec_d = (w_bit != w_par_exp);
            ST_STOP: begin
                if (w_sample_dec) begin
                    stp_err_d    = !w_bit;
                    par_err_d    = par_err_rec_q;
                    data_valid_d = w_bit && !par_err_rec_q;
                    if (w_bit && !par_err_rec_q) p_data_d = shift_q;
                    if (!w_bit) armed_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            armed_q       <= 1'b1;
            prescale_q    <= PRESCALE_W'(PRESCALE_8);
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            shift_q       <= '0;
            par_err_rec_q <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            prescale_q    <= prescale_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            shift_q       <= shift_d;
            par_err_rec_q <= par_err_rec_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign Par_Err    = par_err_q;
    assign Stp_Err    = stp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
//  Module   : tb_uart_rx_deserializer
//  Purpose  : Self-checking bench for uart_rx_deserializer (scoreboard of
//             expected frame events versus observed output pulses).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err, busy;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct {
        int         t;     // absolute edge stamp; -1 = timing not checked
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .Par_Err    (par_err),
        .Stp_Err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (data_valid || par_err || stp_err) begin
            e.t = edge_n; e.dv = data_valid; e.pe = par_err; e.se = stp_err; e.data = p_data;
            obs_q.push_back(e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Latency = observed edge stamp minus the stamp of the first start-bit drive.
    task automatic send_frame(input int p, input logic [7:0] data, input bit with_par,
                              input bit par_bit, input bit stop_bit, input int g_bit,
                              input int g_edge, input int cut, output int t0);
        logic bits [0:10];
        int nb;
        int n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (with_par) begin bits[nb] = par_bit; nb = nb + 1; end
        bits[nb] = stop_bit;
        nb = nb + 1;
        n  = 0;
        t0 = edge_n;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < p; e++) begin
                if (cut > 0 && n >= cut) return;
                @(negedge clk);
                if (b == 0 && e == 0) t0 = edge_n;
                rx = bits[b] ^ ((b == g_bit) && (e == g_edge));
                n = n + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); rx = 1'b1; end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got=%h want=000", {p_data, data_valid, par_err, stp_err, busy});
        end
        rst = 1'b0;
        idle(4);
        total++;
        if ({busy, obs_q.size() == 0} !== 2'b01) begin
            bad++;
            $display("FAIL reset_idle busy=%b events=%0d want busy=0 events=0", busy, obs_q.size());
        end
    endtask

    task automatic test_parity;
        int t0;
        ev_t x, o;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        send_frame(8, 8'hA5, 1, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{t0 + 86, 1'b1, 1'b0, 1'b0, 8'hA5});
        idle(4);
        par_typ = 1'b1;
        send_frame(8, 8'hA5, 1, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{t0 + 86, 1'b0, 1'b1, 1'b0, 8'hA5});
        idle(4);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL parity_event missing want dv=%b pe=%b se=%b", x.dv, x.pe, x.se);
            end else begin
                o = obs_q.pop_front();
                if ({o.dv, o.pe, o.se, o.data} !== {x.dv, x.pe, x.se, x.data} || (x.t >= 0 && o.t != x.t)) begin
                    bad++;
                    $display("FAIL parity_event got t=%0d dv=%b pe=%b se=%b d=%h want t=%0d dv=%b pe=%b se=%b d=%h",
                             o.t, o.dv, o.pe, o.se, o.data, x.t, x.dv, x.pe, x.se, x.data);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL parity_extra got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_stop_break;
        int t0;
        int busy_seen;
        ev_t x, o;
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
        send_frame(16, 8'h3C, 0, 0, 0, -1, 0, 0, t0);
        exp_q.push_back('{-1, 1'b0, 1'b0, 1'b1, 8'hA5});
        busy_seen = 0;
        repeat (60) begin
            @(negedge clk); rx = 1'b0;
            if (busy) busy_seen++;
        end
        total++;
        if (busy_seen != 0) begin bad++; $display("FAIL break_no_restart busy_cycles=%0d want=0", busy_seen); end
        idle(2);
        send_frame(16, 8'h3C, 0, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{-1, 1'b1, 1'b0, 1'b0, 8'h3C});
        idle(4);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL break_event missing want dv=%b pe=%b se=%b", x.dv, x.pe, x.se);
            end else begin
                o = obs_q.pop_front();
                if ({o.dv, o.pe, o.se, o.data} !== {x.dv, x.pe, x.se, x.data}) begin
                    bad++;
                    $display("FAIL break_event got dv=%b pe=%b se=%b d=%h want dv=%b pe=%b se=%b d=%h",
                             o.dv, o.pe, o.se, o.data, x.dv, x.pe, x.se, x.data);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL break_extra got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_glitch;
        int busy_seen;
        prescale = 6'd8; par_en = 1'b0;
        busy_seen = 0;
        repeat (3) begin @(negedge clk); rx = 1'b0; end
        repeat (12) begin
            @(negedge clk); rx = 1'b1;
            if (busy) busy_seen++;
        end
        total++;
        if (busy_seen == 0 || busy !== 1'b0) begin
            bad++; $display("FAIL glitch_busy seen=%0d final=%b want seen>0 final=0", busy_seen, busy);
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL glitch_pulses got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int t0;
        ev_t x, o;
        prescale = 6'd32; par_en = 1'b0;
        send_frame(32, 8'h01, 0, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{-1, 1'b1, 1'b0, 1'b0, 8'h01});
        send_frame(32, 8'hFF, 0, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{-1, 1'b1, 1'b0, 1'b0, 8'hFF});
        idle(4);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL b2b_event missing want d=%h", x.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.dv, o.pe, o.se, o.data} !== {x.dv, x.pe, x.se, x.data}) begin
                    bad++;
                    $display("FAIL b2b_event got dv=%b pe=%b se=%b d=%h want dv=%b pe=%b se=%b d=%h",
                             o.dv, o.pe, o.se, o.data, x.dv, x.pe, x.se, x.data);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        int t0;
        ev_t x, o;
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8, 8'hC3, 0, 0, 1, -1, 0, 30, t0);
        @(negedge clk); rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        total++;
        if ({p_data, data_valid, par_err, stp_err, busy} !== 12'h000) begin
            bad++;
            $display("FAIL midframe_reset got=%h want=000", {p_data, data_valid, par_err, stp_err, busy});
        end
        rst = 1'b0;
        idle(3);
        send_frame(8, 8'h5A, 0, 0, 1, -1, 0, 0, t0);
        exp_q.push_back('{t0 + 78, 1'b1, 1'b0, 1'b0, 8'h5A});
        idle(4);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL after_reset_event missing want d=%h", x.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.dv, o.pe, o.se, o.data} !== {x.dv, x.pe, x.se, x.data} || o.t != x.t) begin
                    bad++;
                    $display("FAIL after_reset_event got t=%0d dv=%b d=%h want t=%0d dv=%b d=%h",
                             o.t, o.dv, o.data, x.t, x.dv, x.data);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL after_reset_extra got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    // Glitch at edge P/2 never reaches the decision; at P/2+1 only voting hides it.
    task automatic test_majority;
        int t0;
        ev_t x, o;
        logic [7:0] late_exp;
`ifdef UART_RX_MAJORITY_VOTE_EN
        late_exp = 8'h5A;
`else
        late_exp = 8'h5B;
`endif
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8, 8'h5A, 0, 0, 1, 1, 4, 0, t0);
        exp_q.push_back('{t0 + 78, 1'b1, 1'b0, 1'b0, 8'h5A});
        idle(4);
        send_frame(8, 8'h5A, 0, 0, 1, 1, 5, 0, t0);
        exp_q.push_back('{t0 + 78, 1'b1, 1'b0, 1'b0, late_exp});
        idle(4);
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL vote_event missing want d=%h", x.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.dv, o.pe, o.se, o.data} !== {x.dv, x.pe, x.se, x.data} || o.t != x.t) begin
                    bad++;
                    $display("FAIL vote_event got t=%0d dv=%b d=%h want t=%0d dv=%b d=%h",
                             o.t, o.dv, o.data, x.t, x.dv, x.data);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL vote_extra got=%0d events want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        test_reset();
        test_parity();
        test_stop_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_majority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
